// File: rtl/sw_seq_pkg.sv
// Shared definitions for the switch sequencer: FSM state encoding and the
// six-entry switch-code table driven into the LED state machine.
package sw_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } seq_state_e;

  localparam logic [2:0] LAST_STEP = 3'd5;

  localparam logic [2:0] SEQ_0 = 3'b001;
  localparam logic [2:0] SEQ_1 = 3'b010;
  localparam logic [2:0] SEQ_2 = 3'b100;
  localparam logic [2:0] SEQ_3 = 3'b111;
  localparam logic [2:0] SEQ_4 = 3'b100;
  localparam logic [2:0] SEQ_5 = 3'b000;

  function automatic logic [2:0] seq_code(input logic [2:0] idx);
    logic [2:0] code;
    case (idx)
      3'd0:    code = SEQ_0;
      3'd1:    code = SEQ_1;
      3'd2:    code = SEQ_2;
      3'd3:    code = SEQ_3;
      3'd4:    code = SEQ_4;
      3'd5:    code = SEQ_5;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Per-step dwell counter: counts 0..DWELL-1 while enabled and flags the last
// cycle with a one-cycle expire; equality compare only, so it never wraps.
module dwell_timer #(
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] r_cnt;

  assign expire = en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= expire ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sw_sequencer.sv
// Drives a fixed switch-code sequence into an LED state machine, holding each
// code for DWELL cycles and checking the LED feedback before advancing.
module sw_sequencer
  import sw_seq_pkg::*;
#(
  parameter int unsigned DWELL   = 50_000_000,
  parameter int unsigned LOOP_EN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] led,
  output logic [2:0] sw,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] step
);

  seq_state_e r_state, w_state_d;
  logic [2:0] r_step, w_step_d;
  logic [2:0] r_sw, w_sw_d;
  logic       r_busy, r_done, r_err;
  logic       w_expire, w_timer_clr, w_timer_en;

  assign w_timer_en  = (r_state == RUN);
  // Hold the counter at zero outside RUN and on abort so every step starts fresh.
  assign w_timer_clr = (r_state != RUN) || stop;

  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_timer_clr),
    .en    (w_timer_en),
    .expire(w_expire)
  );

  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    unique case (r_state)
      IDLE: begin
        w_step_d = 3'd0;
        if (start && !stop) begin
          w_state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state_d = IDLE;
          w_step_d  = 3'd0;
        end else if (w_expire) begin
          if (led != seq_code(r_step)) begin
            w_state_d = ERROR;
          end else if (r_step != LAST_STEP) begin
            w_step_d = r_step + 3'd1;
          end else if (LOOP_EN != 0) begin
            w_step_d = 3'd0;
          end else begin
            w_state_d = DONE;
            w_step_d  = 3'd0;
          end
        end
      end
      DONE: begin
        w_state_d = IDLE;
        w_step_d  = 3'd0;
      end
      ERROR: begin
        // Failing step index stays visible until the abort.
        if (stop) begin
          w_state_d = IDLE;
          w_step_d  = 3'd0;
        end
      end
      default: begin
        w_state_d = IDLE;
        w_step_d  = 3'd0;
      end
    endcase
    w_sw_d = (w_state_d == RUN) ? seq_code(w_step_d) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_step  <= 3'd0;
      r_sw    <= 3'b000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      r_sw    <= w_sw_d;
      r_busy  <= (w_state_d == RUN);
      r_done  <= (w_state_d == DONE);
      r_err   <= (w_state_d == ERROR);
    end
  end

  assign sw   = r_sw;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign step = r_step;

endmodule

// File: doc/sw_sequencer.md
SW_SEQUENCER -- requirements
Module: sw_sequencer

Interface
REQ-001 Parameter DWELL, default 50_000_000, is the number of clock cycles each step is held; legal range 2..2^26-1.
REQ-002 Parameter LOOP_EN, default 0: 1 means repeat the sequence indefinitely, 0 means run it once.
REQ-003 clk  input  1  single system clock; all logic is rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  level; sampled each cycle; starts a run from IDLE.
REQ-006 stop  input  1  level; aborts any activity.
REQ-007 led  input  3  feedback from the LED state machine being sequenced.
REQ-008 sw  output  3  registered switch code driven into the LED state machine.
REQ-009 busy  output  1  high in RUN.
REQ-010 done  output  1  one-cycle pulse at the end of a single-shot run.
REQ-011 err  output  1  sticky mismatch flag.
REQ-012 step  output  3  index of the current sequence entry, 0..5.

Function
REQ-013 The sequence table SHALL be, in order: 3'b001, 3'b010, 3'b100, 3'b111, 3'b100, 3'b000.
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, DONE, ERROR.
REQ-015 IDLE: sw=000, step=0, busy=0; on start=1 and stop=0, the next cycle is RUN with sw=001, step=0, counter=0.
REQ-016 RUN: the dwell counter SHALL increment by 1 each cycle from 0.
REQ-017 RUN, at counter==DWELL-1: the block SHALL compare led against table[step].
REQ-018 RUN, compare matches and step<5: the next cycle has step=step+1, sw=table[step+1], counter=0.
REQ-019 RUN, compare matches, step==5, LOOP_EN=1: the next cycle has step=0, sw=001, counter=0.
REQ-020 RUN, compare matches, step==5, LOOP_EN=0: the next cycle is DONE.
REQ-021 RUN, compare mismatches: the next cycle is ERROR with sw=000 and err=1.
REQ-022 DONE SHALL last exactly one cycle with done=1 and sw=000, then go to IDLE.
REQ-023 ERROR SHALL hold sw=000, busy=0 and err=1 until stop=1, then go to IDLE with err cleared on the following cycle.
REQ-024 stop=1 in IDLE, RUN or DONE SHALL force IDLE on the next cycle: sw=000, step=0, counter=0, no done pulse.
REQ-025 If start and stop are both high, stop SHALL win.
REQ-026 start in RUN, DONE or ERROR SHALL be ignored.
REQ-027 start held high through DONE SHALL begin a new run only from IDLE (one cycle after DONE).
REQ-028 The counter SHALL be $clog2(DWELL) bits wide and compare with equality only; it never wraps, because it is cleared at DWELL-1.
REQ-029 All outputs SHALL be registered; sw changes on the same edge as the state change.
REQ-030 The led compare allows one cycle of downstream latency; DWELL>=2 guarantees settled feedback.

Reset
REQ-031 On rst=0 at a rising clk edge, the block SHALL enter IDLE with sw=000, busy=0, done=0, err=0, step=0, counter=0.
REQ-032 Reset mid-RUN or in ERROR SHALL abort immediately, with no done pulse and err cleared.
REQ-033 Reset SHALL override start and stop.

Structure
REQ-034 A shared package sw_seq_pkg SHALL hold the state encoding constants (IDLE, RUN, DONE, ERROR) and the 6-entry sequence table constants.
REQ-035 One sub-module, dwell_timer, SHALL be used: parameter DWELL, inputs clk, rst, clr, en, and a one-cycle output expire at count DWELL-1.
REQ-036 The FSM, step register and compare logic SHALL live in sw_sequencer.

Verification
REQ-037 DWELL=4, LOOP_EN=0, led driven by a correct LED-FSM model, start pulsed -> sw = 001, 010, 100, 111, 100, 000 each held 4 cycles, then done=1 for exactly 1 cycle, busy=0, err=0.
REQ-038 DWELL=4, LOOP_EN=1 -> after step 5, step returns to 0 with sw=001 and no done pulse; stop at any point -> sw=000, busy=0 next cycle.
REQ-039 DWELL=4, led forced to 3'b000 during step 1 -> at the step-1 compare, the next cycle has err=1, sw=000; stop -> IDLE, and err=0 one cycle later.
REQ-040 start and stop high together in IDLE -> block stays IDLE, sw=000, busy=0.
REQ-041 rst=0 asserted during step 3 of a run -> next edge: all outputs 0, state IDLE; after rst=1 and start -> sw=001, step=0.
REQ-042 start held continuously, LOOP_EN=0 -> DONE, then IDLE for 1 cycle, then a new run with sw=001.
